// File: rtl/fft_stream_framer.sv
// fft_stream_framer
// Buffers an unthrottled complex sample stream in a small FIFO and presents it
// to a streaming FFT core as framed beats (valid/ready with sop/eop), holding
// the FFT in reset for a fixed number of cycles after the framer leaves reset.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   in_real, in_imag          input sample (DATA_W each), in_valid qualifies
//   cfg_pts                   requested frame length (illegal -> 2^MAX_PTS_LOG2)
//   ovf_clr                   clears the sticky overflow flag
//   fft_reset_n               reset to the downstream FFT
//   sink_valid/ready/sop/eop  framed stream handshake
//   sink_real, sink_imag      stream data
//   sink_fftpts               length of the frame being streamed
//   overflow                  sticky: a sample was dropped on a full FIFO
//   frame_count               completed frames (only when FFT_FRAMER_FRAME_CNT_EN)
//
// Build option: define FFT_FRAMER_FRAME_CNT_EN to build the frame counter;
// otherwise frame_count is tied to zero.
//
// state   | meaning
// STARTUP | FFT held in reset, input samples discarded
// IDLE    | waiting for data, frame length tracks cfg_pts
// STREAM  | frame in progress, frame length frozen until eop transfers
module fft_stream_framer #(
  parameter int DATA_W       = 14,
  parameter int MAX_PTS_LOG2 = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int STARTUP_CYC  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       in_real,
  input  logic [DATA_W-1:0]       in_imag,
  input  logic                    in_valid,
  input  logic [MAX_PTS_LOG2:0]   cfg_pts,
  input  logic                    ovf_clr,
  output logic                    fft_reset_n,
  output logic                    sink_valid,
  output logic                    sink_sop,
  output logic                    sink_eop,
  input  logic                    sink_ready,
  output logic [DATA_W-1:0]       sink_real,
  output logic [DATA_W-1:0]       sink_imag,
  output logic [MAX_PTS_LOG2:0]   sink_fftpts,
  output logic                    overflow,
  output logic [15:0]             frame_count
);

  localparam int PTS_W = MAX_PTS_LOG2 + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam logic [PTS_W-1:0] PTS_MAX = PTS_W'(1) << MAX_PTS_LOG2;

  typedef enum logic [1:0] {STARTUP, IDLE, STREAM} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        su_cnt;
  logic [2*DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [MAX_PTS_LOG2-1:0] idx;
  logic [PTS_W-1:0]        len;
  logic                    active, empty, full, pop, accept, drop, last_beat;

  // Only powers of two from 8 up are legal; anything else runs maximum length.
  function automatic logic [PTS_W-1:0] legal_len(input logic [PTS_W-1:0] p);
    if (p >= PTS_W'(8) && (p & (p - PTS_W'(1))) == '0)
      return p;
    else
      return PTS_MAX;
  endfunction

  assign active    = (state != STARTUP);
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign sink_valid = active && !empty;
  assign pop       = sink_valid && sink_ready;
  // A full FIFO still takes a sample when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign accept    = in_valid && active && (!full || pop);
  assign drop      = in_valid && active && full && !pop;
  assign last_beat = ({1'b0, idx} == (len - PTS_W'(1)));
  assign wr_nxt    = accept ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_nxt    = pop ? rd_ptr + (AW+1)'(1) : rd_ptr;

  assign sink_sop    = sink_valid && (idx == '0);
  assign sink_eop    = sink_valid && last_beat;
  assign sink_real   = sink_valid ? mem[rd_ptr[AW-1:0]][2*DATA_W-1:DATA_W] : '0;
  assign sink_imag   = sink_valid ? mem[rd_ptr[AW-1:0]][DATA_W-1:0] : '0;
  assign sink_fftpts = len;

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= {in_real, in_imag};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= STARTUP;
      su_cnt      <= CNT_W'(STARTUP_CYC - 1);
      fft_reset_n <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      idx         <= '0;
      len         <= PTS_MAX;
      overflow    <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;

      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;

      if (pop)
        idx <= last_beat ? '0 : idx + MAX_PTS_LOG2'(1);

      // Length tracks cfg_pts only while nothing is presented in IDLE, and
      // is re-sampled at each frame boundary.
      if (pop && last_beat)
        len <= legal_len(cfg_pts);
      else if (state == IDLE && !sink_valid)
        len <= legal_len(cfg_pts);

      case (state)
        STARTUP: begin
          if (su_cnt == '0) begin
            state       <= IDLE;
            fft_reset_n <= 1'b1;
          end else begin
            su_cnt <= su_cnt - CNT_W'(1);
          end
        end
        IDLE: begin
          if (sink_valid)
            state <= STREAM;
        end
        STREAM: begin
          if (pop && last_beat && (wr_nxt == rd_nxt))
            state <= IDLE;
        end
        default: state <= STARTUP;
      endcase
    end
  end

`ifdef FFT_FRAMER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      frame_cnt_q <= '0;
    else if (pop && last_beat)
      frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_fft_stream_framer.sv
// tb_fft_stream_framer
// Directed self-checking bench for fft_stream_framer with default parameters.
module tb_fft_stream_framer;

  localparam int DATA_W       = 14;
  localparam int MAX_PTS_LOG2 = 10;
  localparam int FIFO_DEPTH   = 16;
  localparam int STARTUP_CYC  = 10;

`ifdef FFT_FRAMER_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [DATA_W-1:0]     in_real, in_imag;
  logic                  in_valid;
  logic [MAX_PTS_LOG2:0] cfg_pts;
  logic                  ovf_clr;
  logic                  fft_reset_n;
  logic                  sink_valid, sink_sop, sink_eop, sink_ready;
  logic [DATA_W-1:0]     sink_real, sink_imag;
  logic [MAX_PTS_LOG2:0] sink_fftpts;
  logic                  overflow;
  logic [15:0]           frame_count;

  int checks = 0;
  int errors = 0;

  fft_stream_framer #(
    .DATA_W(DATA_W), .MAX_PTS_LOG2(MAX_PTS_LOG2),
    .FIFO_DEPTH(FIFO_DEPTH), .STARTUP_CYC(STARTUP_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_real(in_real), .in_imag(in_imag),
    .in_valid(in_valid), .cfg_pts(cfg_pts), .ovf_clr(ovf_clr),
    .fft_reset_n(fft_reset_n), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_ready(sink_ready), .sink_real(sink_real),
    .sink_imag(sink_imag), .sink_fftpts(sink_fftpts), .overflow(overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [MAX_PTS_LOG2:0] pts);
    reset_n = 1'b0; in_valid = 1'b0; sink_ready = 1'b0; ovf_clr = 1'b0;
    in_real = '0; in_imag = '0; cfg_pts = pts;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (STARTUP_CYC) step();
    checks++;
    if (fft_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL do_reset_fft_up: got %b expected 1", fft_reset_n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; sink_ready = 1'b1; ovf_clr = 1'b0;
    in_real = '0; in_imag = '0; cfg_pts = 11'd8;
    repeat (2) step();
    checks++;
    if ({fft_reset_n, sink_valid, sink_sop, sink_eop, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {fft_reset_n, sink_valid, sink_sop, sink_eop, overflow});
    end
    checks++;
    if (sink_real !== '0 || sink_imag !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h/%0h expected 0/0", sink_real, sink_imag);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
    end
    checks++;
    if (sink_fftpts !== 11'd1024) begin
      errors++;
      $display("FAIL reset_fftpts: got %0d expected 1024", sink_fftpts);
    end
  endtask

  task automatic test_startup();
    int low_cnt;
    bit bad;
    reset_n = 1'b0; in_valid = 1'b1; sink_ready = 1'b1; cfg_pts = 11'd8;
    in_real = 14'd5; in_imag = 14'd6;
    repeat (2) step();
    reset_n = 1'b1;
    low_cnt = 0; bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (fft_reset_n === 1'b1) break;
      low_cnt++;
      if (sink_valid !== 1'b0 || overflow !== 1'b0) bad = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (low_cnt !== STARTUP_CYC) begin
      errors++;
      $display("FAIL startup_len: got %0d cycles expected %0d", low_cnt, STARTUP_CYC);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL startup_quiet: got valid/overflow activity expected none");
    end
    checks++;
    if (sink_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL startup_discard: got valid=%b ovf=%b expected 0/0", sink_valid, overflow);
    end
  endtask

  task automatic test_single_frame();
    int n;
    do_reset(11'd8);
    sink_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_real = DATA_W'(c + 1); in_imag = DATA_W'(500 + c + 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (sink_valid === 1'b1) begin
        checks++;
        if (sink_real !== DATA_W'(n + 1) || sink_imag !== DATA_W'(500 + n + 1)) begin
          errors++;
          $display("FAIL single_data: got %0d/%0d expected %0d/%0d",
                   sink_real, sink_imag, n + 1, 500 + n + 1);
        end
        checks++;
        if (sink_sop !== (n == 0) || sink_eop !== (n == 7) || sink_fftpts !== 11'd8) begin
          errors++;
          $display("FAIL single_frame_beat%0d: got sop=%b eop=%b pts=%0d expected %b %b 8",
                   n, sink_sop, sink_eop, sink_fftpts, n == 0, n == 7);
        end
        checks++;
        if (c !== n) begin
          errors++;
          $display("FAIL single_consecutive: got beat %0d in cycle %0d expected cycle %0d", n, c, n);
        end
        n++;
      end
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL single_beats: got %0d expected 8", n);
    end
    checks++;
    if (frame_count !== (CNT_EN ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL single_frame_count: got %0d expected %0d", frame_count, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit unstable;
    do_reset(11'd16);
    sink_ready = 1'b0;
    unstable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_real = DATA_W'(c + 1); in_imag = DATA_W'(2000 + c + 1);
      step();
      if (sink_valid !== 1'b1 || sink_real !== 14'd1 || sink_imag !== 14'd2001 ||
          sink_sop !== 1'b1 || sink_fftpts !== 11'd16)
        unstable = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL bp_hold: got changing head while stalled expected sample 1 held");
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %b expected 1", overflow);
    end
    sink_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (sink_valid === 1'b1) begin
        checks++;
        if (sink_real !== DATA_W'(n + 1) || sink_imag !== DATA_W'(2000 + n + 1) ||
            sink_sop !== (n == 0) || sink_eop !== (n == 15)) begin
          errors++;
          $display("FAIL bp_drain_beat%0d: got %0d sop=%b eop=%b expected %0d sop=%b eop=%b",
                   n, sink_real, sink_sop, sink_eop, n + 1, n == 0, n == 15);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL bp_stored: got %0d expected 16", n);
    end
  endtask

  task automatic test_length_change();
    int n;
    do_reset(11'd16);
    sink_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if (c < 48) begin
        in_valid = 1'b1; in_real = DATA_W'(c + 1); in_imag = DATA_W'(c + 3);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (sink_valid === 1'b1) begin
        checks++;
        if (sink_real !== DATA_W'(n + 1) || sink_sop !== (n == 0 || n == 16) ||
            sink_eop !== (n == 15 || n == 47) ||
            sink_fftpts !== ((n < 16) ? 11'd16 : 11'd32)) begin
          errors++;
          $display("FAIL len_beat%0d: got %0d sop=%b eop=%b pts=%0d expected %0d %b %b %0d",
                   n, sink_real, sink_sop, sink_eop, sink_fftpts, n + 1,
                   n == 0 || n == 16, n == 15 || n == 47, (n < 16) ? 16 : 32);
        end
        n++;
        if (n == 5) cfg_pts = 11'd32;
      end
    end
    checks++;
    if (n !== 48) begin
      errors++;
      $display("FAIL len_beats: got %0d expected 48", n);
    end
    checks++;
    if (frame_count !== (CNT_EN ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL len_frame_count: got %0d expected %0d", frame_count, CNT_EN ? 2 : 0);
    end
    cfg_pts = 11'd12;
    step();
    checks++;
    if (sink_fftpts !== 11'd1024) begin
      errors++;
      $display("FAIL len_illegal_idle: got %0d expected 1024", sink_fftpts);
    end
    in_valid = 1'b1; in_real = 14'd99;
    step();
    in_valid = 1'b0;
    checks++;
    if (sink_sop !== 1'b1 || sink_real !== 14'd99 || sink_fftpts !== 11'd1024) begin
      errors++;
      $display("FAIL len_illegal_sop: got sop=%b data=%0d pts=%0d expected 1 99 1024",
               sink_sop, sink_real, sink_fftpts);
    end
  endtask

  task automatic test_full_pop();
    int n;
    bit bad;
    do_reset(11'd16);
    sink_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_real = DATA_W'(c + 1); in_imag = '0;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fp_fill_no_ovf: got %b expected 0", overflow);
    end
    sink_ready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_real = DATA_W'(17 + c);
      if (sink_valid !== 1'b1 || sink_real !== DATA_W'(c + 1)) bad = 1'b1;
      step();
    end
    in_valid = 1'b0; sink_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fp_pop_order: got wrong head during full+pop expected samples 1..10");
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fp_no_drop: got %b expected 0", overflow);
    end
    in_valid = 1'b1; in_real = 14'd90;
    step();
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL fp_drop_sets: got %b expected 1", overflow);
    end
    in_valid = 1'b1; in_real = 14'd91; ovf_clr = 1'b1;
    step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL fp_clr_with_drop: got %b expected 1", overflow);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fp_clr: got %b expected 0", overflow);
    end
    sink_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (sink_valid === 1'b1) begin
        checks++;
        if (sink_real !== DATA_W'(11 + n) || sink_sop !== (11 + n == 17) ||
            sink_eop !== (11 + n == 16)) begin
          errors++;
          $display("FAIL fp_drain_beat%0d: got %0d sop=%b eop=%b expected %0d %b %b",
                   n, sink_real, sink_sop, sink_eop, 11 + n, 11 + n == 17, 11 + n == 16);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL fp_stored: got %0d expected 16", n);
    end
  endtask

  task automatic test_reset_mid_frame();
    int low_cnt;
    bit eop_seen;
    do_reset(11'd8);
    sink_ready = 1'b1;
    eop_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_real = DATA_W'(c + 1); in_imag = DATA_W'(c + 1);
      step();
      if (sink_eop === 1'b1) eop_seen = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (sink_valid !== 1'b1 || sink_real !== 14'd5) begin
      errors++;
      $display("FAIL mid_beat5: got valid=%b data=%0d expected 1 5", sink_valid, sink_real);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if ({fft_reset_n, sink_valid, sink_sop, sink_eop, overflow} !== 5'b0 ||
        sink_real !== '0 || sink_imag !== '0 || frame_count !== 16'd0 ||
        sink_fftpts !== 11'd1024) begin
      errors++;
      $display("FAIL mid_reset_outputs: got flags=%b data=%0d/%0d cnt=%0d pts=%0d expected 0 0/0 0 1024",
               {fft_reset_n, sink_valid, sink_sop, sink_eop, overflow},
               sink_real, sink_imag, frame_count, sink_fftpts);
    end
    checks++;
    if (eop_seen) begin
      errors++;
      $display("FAIL mid_no_eop: got eop asserted expected none");
    end
    reset_n = 1'b1;
    low_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (fft_reset_n === 1'b1) break;
      low_cnt++;
      step();
    end
    checks++;
    if (low_cnt !== STARTUP_CYC) begin
      errors++;
      $display("FAIL mid_restart_len: got %0d expected %0d", low_cnt, STARTUP_CYC);
    end
    in_valid = 1'b1; in_real = 14'd77; in_imag = 14'd78;
    step();
    in_valid = 1'b0;
    checks++;
    if (sink_valid !== 1'b1 || sink_sop !== 1'b1 || sink_real !== 14'd77 ||
        sink_imag !== 14'd78 || sink_fftpts !== 11'd8) begin
      errors++;
      $display("FAIL mid_new_sop: got v=%b sop=%b data=%0d/%0d pts=%0d expected 1 1 77/78 8",
               sink_valid, sink_sop, sink_real, sink_imag, sink_fftpts);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_single_frame();
    test_backpressure();
    test_length_change();
    test_full_pop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stream_framer.md
FFT_STREAM_FRAMER -- requirements
Module: fft_stream_framer

Interface
REQ-001 Parameter DATA_W, default 14: bit width of in_real, in_imag, sink_real and sink_imag.
REQ-002 Parameter MAX_PTS_LOG2, default 10: log2 of the largest frame length (1024).
REQ-003 Parameter FIFO_DEPTH, default 16: sample buffer depth; shall be a power of 2 and at least 4.
REQ-004 Parameter STARTUP_CYC, default 10: number of cycles fft_reset_n is held low after reset release.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_real, in_imag  in  DATA_W  sample; no backpressure.
- in_valid  in  1  sample present this cycle.
- cfg_pts  in  MAX_PTS_LOG2+1  requested frame length.
- ovf_clr  in  1  clears overflow.
- fft_reset_n  out  1  reset to the downstream FFT.
- sink_valid, sink_sop, sink_eop  out  1  stream framing.
- sink_ready  in  1  FFT accepts a beat.
- sink_real, sink_imag  out  DATA_W  stream data.
- sink_fftpts  out  MAX_PTS_LOG2+1  length of the current frame.
- overflow  out  1  sticky flag: a sample was dropped.
- frame_count  out  16  count of completed frames.

Function
REQ-006 FSM states: STARTUP, IDLE, STREAM. After reset the FSM is in STARTUP and counts STARTUP_CYC cycles, then enters IDLE; fft_reset_n is high only outside STARTUP.
REQ-007 In STARTUP, in_valid samples are discarded and overflow is not set.
REQ-008 Outside STARTUP, each in_valid cycle writes {in_real,in_imag} to the FIFO, except when the FIFO is full with no pop in the same cycle; in that case the sample is dropped and overflow is set.
REQ-009 A write to a full FIFO in the same cycle as a pop is accepted; no overflow.
REQ-010 A beat transfers when sink_valid and sink_ready are both high. While sink_valid is high and sink_ready is low, sink_* shall hold stable.
REQ-011 sink_valid is high whenever the FIFO is non-empty outside STARTUP. A sample written at edge k into an empty FIFO drives sink_valid high in the cycle after edge k (1-cycle latency).
REQ-012 Frame length L: taken from cfg_pts. Legal values are powers of 2 from 8 to 2^MAX_PTS_LOG2; any other value is replaced by 2^MAX_PTS_LOG2.
REQ-013 In IDLE, L is reloaded every cycle. L is frozen from the first sop beat presentation until the eop beat transfers; sink_fftpts = L for the whole frame.
REQ-014 The beat index idx runs 0..L-1 and increments on each transfer. sink_sop = (idx==0). sink_eop = (idx==L-1).
REQ-015 IDLE->STREAM when sink_valid first rises.
REQ-016 On an eop transfer, idx wraps to 0 and L is reloaded in the same cycle. The FSM stays in STREAM if the FIFO is still non-empty, else goes to IDLE. Back-to-back frames have no gap cycle.
REQ-017 overflow clears on ovf_clr unless a drop occurs in the same cycle, in which case it stays set. Drops do not alter frame boundaries.
REQ-018 frame_count increments by 1 on each eop transfer and wraps from 65535 to 0.

Reset
REQ-019 While reset_n is low at a rising edge, all of the following hold:
- FSM goes to STARTUP.
- FIFO empties.
- idx = 0, L = 2^MAX_PTS_LOG2.
- Outputs: fft_reset_n=0, sink_valid=0, sink_sop=0, sink_eop=0, sink_real=0, sink_imag=0, overflow=0, frame_count=0, sink_fftpts=2^MAX_PTS_LOG2.
REQ-020 A reset mid-frame abandons the frame without asserting sink_eop, and restarts the STARTUP count.

Configuration
REQ-021 Macro FFT_FRAMER_FRAME_CNT_EN:
- Defined: frame_count behaves per REQ-018.
- Undefined: no counter is built and frame_count is tied to 0.
All other behaviour is identical in both cases.

Verification
REQ-022 Startup: release reset, in_valid=1 from cycle 0 -> fft_reset_n low for exactly 10 cycles; no samples stored; overflow=0.
REQ-023 Single frame: cfg_pts=8, sink_ready=1, 8 samples 1..8 -> 8 consecutive beats; sop on sample 1, eop on sample 8; sink_fftpts=8; frame_count=1.
REQ-024 Backpressure: sink_ready=0 for 20 cycles while in_valid=1 continuously, FIFO_DEPTH=16 -> 16 stored; 4 dropped; overflow=1; data held stable. After ready returns, beats are the first 16 samples in order.
REQ-025 Length change: cfg_pts switches 16->32 mid-frame -> current frame eop at beat 16; next frame sop has sink_fftpts=32. cfg_pts=12 -> frame length 1024.
REQ-026 Full+pop: FIFO full, sink_ready=1, in_valid=1 for 10 cycles -> no drops; overflow stays 0. Then ovf_clr pulsed together with a drop -> overflow remains 1.
REQ-027 Reset at beat 5 of an 8-beat frame -> all outputs take their reset values; after startup the next beat carries sop with the new data.
